pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the 5-stage RV32 pipeline: drives enable and flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Resolves load-use hazards, taken-branch/jump redirects, multi-cycle data-memory stalls, and the `halt` drain sequence, with a memory watchdog and a stall performance counter. Sits beside the datapath; inputs come from decoded pipeline-register fields, outputs go to register write-enables/synchronous clears.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the RV32 datapath (master) and the hazard/sequencing controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             ex_halt;
  logic             mem_access;
  logic             dmem_ready;
  logic             wb_halt;
  logic             resume;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic             halted;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, ex_halt,
           mem_access, dmem_ready, wb_halt, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_bubble, halted, mem_err, state, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, ex_memread, ex_rd, ex_branch_taken, ex_halt,
           mem_access, dmem_ready, wb_halt, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           memwb_bubble, halted, mem_err, state, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: load-use bubbles, branch flushes, dmem freezes, halt drain,
// dmem watchdog and a saturating stall counter. Outputs are combinational from state_q.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  localparam int                WAIT_W    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit                WDOG_EN   = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic mem_stall, lu_hazard, count_stall;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_bubble, halted, mem_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign mem_stall = bus.mem_access & ~bus.dmem_ready;
  assign lu_hazard = bus.ex_memread & (bus.ex_rd != 5'd0) &
                     ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));
  // A taken branch squashes the dependent instruction, so its hazard costs no stall.
  assign count_stall = mem_stall | (lu_hazard & ~bus.ex_branch_taken);

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    memwb_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    mem_err      = 1'b0;
    if (reset) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_HALTED: halted = 1'b1;
        ST_ERROR: begin
          halted  = 1'b1;
          mem_err = 1'b1;
        end
        default: begin
          if (mem_stall) begin
            memwb_en     = 1'b1;
            memwb_bubble = 1'b1;
          end else begin
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            pc_en    = (state_q == ST_RUN);
            if (bus.ex_branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (lu_hazard) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
            end else if (bus.ex_halt || (state_q == ST_DRAIN)) begin
              pc_en      = 1'b0;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = '0;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (count_stall) stall_cycles_d = sat_inc(stall_cycles_q);
        if (mem_stall) begin
          if (WDOG_EN && (wait_cnt_q == WAIT_LAST)) state_d = ST_ERROR;
          else if (WDOG_EN) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else if (state_q == ST_RUN) begin
          if (bus.ex_halt && !bus.ex_branch_taken && !lu_hazard) state_d = ST_DRAIN;
        end else if (bus.wb_halt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: if (bus.resume) state_d = ST_RUN;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.idex_en      = idex_en;
  assign bus.exmem_en     = exmem_en;
  assign bus.memwb_en     = memwb_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_flush   = idex_flush;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.halted       = halted;
  assign bus.mem_err      = mem_err;
  assign bus.state        = reset ? ST_RUN : state_q;
  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then randomized traffic,
// expected responses come from an event-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2, M_ERROR = 3;
  localparam int EV_NONE = 0, EV_STALL = 1, EV_BRANCH = 2, EV_HAZARD = 3, EV_HALT = 4, EV_DRAIN = 5;

  typedef struct packed {
    logic [11:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // stimulus values for the next cycle
  logic       s_rst, s_mr, s_br, s_hl, s_ma, s_dr, s_wh, s_rs;
  logic [4:0] s_rs1, s_rs2, s_rd;

  // reference model state
  int m_mode = M_RUN;
  int m_consec = 0;
  int m_cnt = 0;

  task automatic idle();
    s_rst = 1'b0; s_mr = 1'b0; s_br = 1'b0; s_hl = 1'b0; s_ma = 1'b0;
    s_dr = 1'b1; s_wh = 1'b0; s_rs = 1'b0;
    s_rs1 = 5'd0; s_rs2 = 5'd0; s_rd = 5'd0;
  endtask

  task automatic tick();
    logic       ms, lu, hlt, err;
    logic [7:0] en;  // pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, bubble
    int         ev;
    exp_t       e;
    @(posedge clk);
    #1;
    reset               = s_rst;
    bus.id_rs1          = s_rs1;
    bus.id_rs2          = s_rs2;
    bus.ex_memread      = s_mr;
    bus.ex_rd           = s_rd;
    bus.ex_branch_taken = s_br;
    bus.ex_halt         = s_hl;
    bus.mem_access      = s_ma;
    bus.dmem_ready      = s_dr;
    bus.wb_halt         = s_wh;
    bus.resume          = s_rs;
    cyc++;

    ms  = s_ma && !s_dr;
    lu  = s_mr && (s_rd != 0) && ((s_rd == s_rs1) || (s_rd == s_rs2));
    hlt = 1'b0;
    err = 1'b0;
    ev  = EV_NONE;
    if (s_rst) en = 8'b0000_0111;
    else if (m_mode == M_HALTED) begin en = 8'b0; hlt = 1'b1; end
    else if (m_mode == M_ERROR) begin en = 8'b0; hlt = 1'b1; err = 1'b1; end
    else begin
      if (ms)                          ev = EV_STALL;
      else if (s_br)                   ev = EV_BRANCH;
      else if (lu)                     ev = EV_HAZARD;
      else if (m_mode == M_RUN && s_hl) ev = EV_HALT;
      else if (m_mode == M_DRAIN)      ev = EV_DRAIN;
      if (ev == EV_STALL)       en = 8'b0000_1001;
      else if (ev == EV_BRANCH) en = {(m_mode == M_RUN), 7'b1111_110};
      else if (ev == EV_HAZARD) en = 8'b0011_1010;
      else if (ev == EV_HALT || ev == EV_DRAIN) en = 8'b0111_1110;
      else                      en = 8'b1111_1000;
    end
    e.ctl = {en, hlt, err, (s_rst ? 2'd0 : 2'(m_mode))};
    e.cnt = CNT_W'(m_cnt);
    exp_q.push_back(e);

    if (s_rst) begin
      m_mode = M_RUN; m_consec = 0; m_cnt = 0;
    end else if (m_mode == M_RUN || m_mode == M_DRAIN) begin
      if (ms || (lu && !s_br)) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (ms) begin
        m_consec++;
        if (m_consec == MEM_TIMEOUT) m_mode = M_ERROR;
      end else begin
        m_consec = 0;
        if (ev == EV_HALT) m_mode = M_DRAIN;
        else if (m_mode == M_DRAIN && s_wh) m_mode = M_HALTED;
      end
    end else if (m_mode == M_HALTED && s_rs) begin
      m_mode = M_RUN;
    end
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin idle(); tick(); end
  endtask

  // monitor: outputs are combinational, so each driven cycle is judged at the falling edge
  always @(negedge clk) begin
    exp_t       e;
    logic [11:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
             bus.ifid_flush, bus.idex_flush, bus.memwb_bubble, bus.halted, bus.mem_err, bus.state};
      checks++;
      if (got !== e.ctl) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b want=%b (pc,ifid,idex,exmem,memwb,iff,idf,bub,hlt,err,state)",
                 cyc, got, e.ctl);
      end
      checks++;
      if (bus.stall_cycles !== e.cnt) begin
        errors++;
        $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", cyc, bus.stall_cycles, e.cnt);
      end
    end
  end

  initial begin
    int phase_slow;
    int guard;
    idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.ex_memread = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_branch_taken = 1'b0; bus.ex_halt = 1'b0; bus.mem_access = 1'b0;
    bus.dmem_ready = 1'b1; bus.wb_halt = 1'b0; bus.resume = 1'b0;

    // reset
    idle(); s_rst = 1'b1; tick(); tick();
    idles(1);

    // load-use on rs2, then same load with rd=x0
    idle(); s_mr = 1'b1; s_rd = 5'd5; s_rs2 = 5'd5; tick();
    idles(1);
    idle(); s_mr = 1'b1; s_rd = 5'd0; s_rs1 = 5'd0; tick();

    // branch coincident with load-use
    idle(); s_br = 1'b1; s_mr = 1'b1; s_rd = 5'd7; s_rs1 = 5'd7; tick();

    // three dmem wait cycles then completion
    for (int i = 0; i < 3; i++) begin idle(); s_ma = 1'b1; s_dr = 1'b0; tick(); end
    idle(); s_ma = 1'b1; s_dr = 1'b1; tick();

    // halt drain with stall coincident with ex_halt, then resume
    idle(); s_hl = 1'b1; s_ma = 1'b1; s_dr = 1'b0; tick();
    idle(); s_hl = 1'b1; tick();
    idles(1);
    idle(); s_br = 1'b1; tick();
    idle(); s_wh = 1'b1; tick();
    idles(2);
    idle(); s_rs = 1'b1; tick();
    idles(1);

    // watchdog, resume ignored in ERROR, reset recovers
    for (int i = 0; i < 6; i++) begin idle(); s_ma = 1'b1; s_dr = 1'b0; tick(); end
    idle(); s_rs = 1'b1; tick();
    idle(); s_rst = 1'b1; tick();
    idles(1);

    // counter saturation, then reset in the middle of a drain
    for (int i = 0; i < 20; i++) begin idle(); s_mr = 1'b1; s_rd = 5'd3; s_rs1 = 5'd3; tick(); end
    idle(); s_hl = 1'b1; tick();
    idles(1);
    idle(); s_rst = 1'b1; tick();
    idles(2);

    // randomized traffic in phases of normal and slow memory
    phase_slow = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) phase_slow = ($urandom_range(0, 2) == 0);
      s_rst = ($urandom_range(0, 59) == 0);
      s_rs1 = 5'($urandom_range(0, 3));
      s_rs2 = 5'($urandom_range(0, 3));
      s_rd  = 5'($urandom_range(0, 3));
      s_mr  = ($urandom_range(0, 2) == 0);
      s_br  = ($urandom_range(0, 7) == 0);
      s_hl  = ($urandom_range(0, 15) == 0);
      s_ma  = ($urandom_range(0, 1) == 0);
      s_dr  = phase_slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      s_wh  = ($urandom_range(0, 3) == 0);
      s_rs  = ($urandom_range(0, 3) == 0);
      tick();
    end
    idles(1);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_queue left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
